// File: rtl/dvp_pixel_rx.sv
// dvp_pixel_rx: DVP camera capture that packs beats into pixels and sends them on an AXI4-Stream
// master with backpressure, and tracks line/frame geometry plus sticky misalign/overflow flags.
module dvp_pixel_rx #(
   parameter int DIN_WIDTH         = 8,
   parameter int BYTES_PER_PIXEL   = 2,
   parameter int VSYNC_ACTIVE_HIGH = 0,
   parameter int HREF_ACTIVE_HIGH  = 1,
   parameter int CNT_WIDTH         = 12
) (
   input  logic                                 pclk,
   input  logic                                 rst,
   input  logic [DIN_WIDTH-1:0]                 din,
   input  logic                                 href_in,
   input  logic                                 vsync_in,
   output logic [DIN_WIDTH*BYTES_PER_PIXEL-1:0] tdata,
   output logic                                 tvalid,
   input  logic                                 tready,
   output logic                                 tlast,
   output logic                                 tuser,
   input  logic                                 clear_err,
   output logic                                 overflow_err,
   output logic                                 misalign_err,
   output logic [CNT_WIDTH-1:0]                 line_pixels,
   output logic [CNT_WIDTH-1:0]                 frame_lines
);
   localparam int PW = DIN_WIDTH * BYTES_PER_PIXEL;
   localparam logic [CNT_WIDTH-1:0] CMAX = '1;
   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
   localparam logic [1:0] LAST_PH = 2'(BYTES_PER_PIXEL - 1);
   logic href, vsync, href_q, vsync_q, in_line, line_on, fall, last_beat, frame_end;
   logic load, drop, stage_valid, sof_pending;
   logic [1:0] phase;
   logic [PW-1:0] shreg, word, stage_data;
   logic [CNT_WIDTH-1:0] pix_cnt, line_cnt;
   assign href  = href_in ^ (HREF_ACTIVE_HIGH == 0);
   assign vsync = vsync_in ^ (VSYNC_ACTIVE_HIGH == 0);
   // a line opens only on a seen href rise, so capture after a mid-line reset waits for the next line
   assign line_on   = ~vsync & href & (in_line | ~href_q);
   assign fall      = in_line & ~href;
   assign last_beat = line_on & (phase == LAST_PH);
   assign frame_end = vsync & ~vsync_q & (line_cnt != '0);
   assign load      = stage_valid & (~tvalid | tready);
   assign drop      = stage_valid & tvalid & ~tready;
   assign word      = (shreg << DIN_WIDTH) | PW'(din);
   always_ff @(posedge pclk) begin
      if (rst) begin
         href_q       <= 1'b1;
         vsync_q      <= 1'b0;
         in_line      <= 1'b0;
         phase        <= '0;
         shreg        <= '0;
         stage_valid  <= 1'b0;
         stage_data   <= '0;
         sof_pending  <= 1'b1;
         pix_cnt      <= '0;
         line_cnt     <= '0;
         tdata        <= '0;
         tvalid       <= 1'b0;
         tlast        <= 1'b0;
         tuser        <= 1'b0;
         overflow_err <= 1'b0;
         misalign_err <= 1'b0;
         line_pixels  <= '0;
         frame_lines  <= '0;
      end else begin
         href_q      <= href;
         vsync_q     <= vsync;
         in_line     <= line_on;
         if (line_on) shreg <= word;
         phase       <= (last_beat | fall | frame_end) ? '0 : line_on ? phase + 2'd1 : phase;
         stage_valid <= last_beat;
         if (last_beat) stage_data <= word;
         pix_cnt     <= fall ? '0 : (last_beat && pix_cnt != CMAX) ? pix_cnt + ONE : pix_cnt;
         line_cnt    <= frame_end ? '0 : (fall && line_cnt != CMAX) ? line_cnt + ONE : line_cnt;
         if (fall) line_pixels <= pix_cnt;
         if (frame_end) frame_lines <= line_cnt;
         // a held pixel is never overwritten; a blocked staged pixel is simply lost
         if (load) begin
            tdata <= stage_data;
            tlast <= ~href;
            tuser <= sof_pending;
         end
         tvalid       <= load | (tvalid & ~tready);
         sof_pending  <= vsync | (sof_pending & ~load);
         overflow_err <= drop | (overflow_err & ~clear_err);
         misalign_err <= (fall & (phase != '0)) | (misalign_err & ~clear_err);
      end
   end
endmodule
